// File: rtl/vga_capture.sv
// vga_capture: registers a VGA-style pixel stream and writes active pixels into a linear framebuffer.
// Define VGA_CAPTURE_ERR_EN to enable the sticky line/frame geometry error flag on ERR.
module vga_capture #(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HS,
  input  logic        VS,
  input  logic        DE,
  input  logic [23:0] PIX_DATA,
  output logic [18:0] RAM_ADDR,
  output logic [23:0] RAM_WDATA,
  output logic        RAM_WE,
  output logic        FRAME_DONE,
  output logic        LOCKED,
  output logic        ERR
);

  localparam int CW = 16;
  localparam logic [CW-1:0] H_LIM = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_LIM = CW'(V_VISIBLE);

  typedef enum logic {SEEK = 1'b0, CAPTURE = 1'b1} state_t;
  state_t state, state_nxt;

  logic        hs_p1, vs_p1, de_p1, vld_p1;
  logic [23:0] pix_p1;
  logic        vs_p2, de_p2, vld_p2;
  logic        vs_rise, vs_fall, de_fall;

  logic [CW-1:0] pix_cnt, line_cnt, pix_cnt_nxt, line_cnt_nxt;
  logic [18:0]   addr_cnt, addr_cnt_nxt;
  logic          we_nxt, fd_nxt;

  logic          we_p2, fd_p2;
  logic [18:0]   addr_p2;
  logic [23:0]   data_p2;

  // HS is sampled for completeness only; DE edges delimit lines.
  logic unused_hs;
  assign unused_hs = hs_p1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Stage 1: input registers plus one-cycle history for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      de_p1  <= 1'b0;
      pix_p1 <= '0;
      vld_p1 <= 1'b0;
      vs_p2  <= 1'b0;
      de_p2  <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      hs_p1  <= HS;
      vs_p1  <= VS;
      de_p1  <= DE;
      pix_p1 <= PIX_DATA;
      vld_p1 <= 1'b1;
      vs_p2  <= vs_p1;
      de_p2  <= de_p1;
      vld_p2 <= vld_p1;
    end
  end

  // Edges only count once the history register holds a real sample, so a
  // reset released while VS is high never looks like a VS rising edge.
  assign vs_rise = vld_p2 &  vs_p1 & ~vs_p2;
  assign vs_fall = vld_p2 & ~vs_p1 &  vs_p2;
  assign de_fall = vld_p2 & ~de_p1 &  de_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEEK;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == SEEK && vs_rise) state_nxt = CAPTURE;
  end

  assign LOCKED = (state == CAPTURE);

  always_comb begin
    pix_cnt_nxt  = pix_cnt;
    line_cnt_nxt = line_cnt;
    addr_cnt_nxt = addr_cnt;
    we_nxt       = 1'b0;
    fd_nxt       = 1'b0;
    if (state == SEEK) begin
      if (vs_rise) begin
        pix_cnt_nxt  = '0;
        line_cnt_nxt = '0;
        addr_cnt_nxt = '0;
      end
    end else begin
      if (de_p1) begin
        pix_cnt_nxt = sat_inc(pix_cnt);
        if (pix_cnt < H_LIM && line_cnt < V_LIM) begin
          we_nxt       = 1'b1;
          addr_cnt_nxt = addr_cnt + 19'(1);
        end
      end
      if (de_fall) begin
        pix_cnt_nxt  = '0;
        line_cnt_nxt = sat_inc(line_cnt);
      end
      // A pixel coinciding with the frame end is still written at addr_cnt above.
      if (vs_fall) begin
        fd_nxt       = 1'b1;
        pix_cnt_nxt  = '0;
        line_cnt_nxt = '0;
        addr_cnt_nxt = '0;
      end
    end
  end

  // Stage 2: counters and the write decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      addr_cnt <= '0;
      we_p2    <= 1'b0;
      fd_p2    <= 1'b0;
      addr_p2  <= '0;
      data_p2  <= '0;
    end else begin
      pix_cnt  <= pix_cnt_nxt;
      line_cnt <= line_cnt_nxt;
      addr_cnt <= addr_cnt_nxt;
      we_p2    <= we_nxt;
      fd_p2    <= fd_nxt;
      if (we_nxt) begin
        addr_p2 <= addr_cnt;
        data_p2 <= pix_p1;
      end
    end
  end

  // Stage 3: framebuffer port; address/data hold between writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RAM_WE     <= 1'b0;
      FRAME_DONE <= 1'b0;
      RAM_ADDR   <= '0;
      RAM_WDATA  <= '0;
    end else begin
      RAM_WE     <= we_p2;
      FRAME_DONE <= fd_p2;
      if (we_p2) begin
        RAM_ADDR  <= addr_p2;
        RAM_WDATA <= data_p2;
      end
    end
  end

`ifdef VGA_CAPTURE_ERR_EN
  logic          err_q, err_set;
  logic [CW-1:0] lines_at_end;

  always_comb begin
    lines_at_end = de_fall ? sat_inc(line_cnt) : line_cnt;
    err_set      = (state == CAPTURE) &&
                   ((de_fall && pix_cnt != H_LIM) || (vs_fall && lines_at_end != V_LIM));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_q <= 1'b0;
    else if (vs_rise) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture on a reduced 16x6 geometry with a queue-based frame model.
module tb_vga_capture;
  localparam int H = 16;
  localparam int V = 6;
`ifdef VGA_CAPTURE_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, HS, VS, DE;
  logic [23:0] PIX_DATA;
  logic [18:0] RAM_ADDR;
  logic [23:0] RAM_WDATA;
  logic        RAM_WE, FRAME_DONE, LOCKED, ERR;

  always #5 clk = ~clk;

  vga_capture #(.H_VISIBLE(H), .V_VISIBLE(V)) dut (
    .clk(clk), .rst(rst), .HS(HS), .VS(VS), .DE(DE), .PIX_DATA(PIX_DATA),
    .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA), .RAM_WE(RAM_WE),
    .FRAME_DONE(FRAME_DONE), .LOCKED(LOCKED), .ERR(ERR)
  );

  int checks = 0;
  int errors = 0;

  logic [42:0] wr_q[$];
  logic [42:0] exp_q[$];
  int fd_cnt = 0;
  bit exp_err;
  int line_len[32];
  int nlines;
  int data_mode;

  always @(posedge clk) begin
    #1;
    if (RAM_WE === 1'b1) wr_q.push_back({RAM_ADDR, RAM_WDATA});
    if (FRAME_DONE === 1'b1) fd_cnt++;
  end

  task automatic drive(input logic vs, input logic de, input logic hs, input logic [23:0] pix);
    @(negedge clk);
    VS = vs; DE = de; HS = hs; PIX_DATA = pix;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; VS = 1'b0; DE = 1'b0; HS = 1'b1; PIX_DATA = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Expected writes: each visible pixel of a visible line takes the next address in the frame.
  task automatic drive_frame();
    int k;
    logic [23:0] d;
    k = 0;
    exp_q.delete();
    exp_err = (nlines != V);
    repeat (5) drive(1'b0, 1'b0, 1'b1, 24'h0);
    wr_q.delete();
    fd_cnt = 0;
    repeat (2) drive(1'b1, 1'b0, 1'b1, 24'h0);
    for (int l = 0; l < nlines; l++) begin
      if (line_len[l] != H) exp_err = 1'b1;
      for (int p = 0; p < line_len[l]; p++) begin
        d = (data_mode != 0) ? 24'(l * H + p) : 24'($urandom);
        drive(1'b1, 1'b1, 1'b1, d);
        if (l < V && p < H) begin
          exp_q.push_back({19'(k), d});
          k++;
        end
      end
      drive(1'b1, 1'b0, 1'b1, 24'h0);
      drive(1'b1, 1'b0, 1'b0, 24'h0);
      drive(1'b1, 1'b0, 1'b1, 24'h0);
    end
    repeat (2) drive(1'b1, 1'b0, 1'b1, 24'h0);
    repeat (6) drive(1'b0, 1'b0, 1'b1, 24'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1; VS = 1'b0; DE = 1'b0; HS = 1'b1; PIX_DATA = '0;
    #1;
    checks++; if (RAM_WE !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", RAM_WE); end
    checks++; if (RAM_ADDR !== 19'h0) begin errors++; $display("FAIL reset_addr got %h want 0", RAM_ADDR); end
    checks++; if (RAM_WDATA !== 24'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", RAM_WDATA); end
    checks++; if (FRAME_DONE !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", FRAME_DONE); end
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", LOCKED); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", ERR); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_seek();
    int locked_seen;
    locked_seen = 0;
    @(negedge clk);
    rst = 1'b1; VS = 1'b1; DE = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr_q.delete();
    for (int l = 0; l < 3; l++) begin
      for (int p = 0; p < H; p++) begin
        drive(1'b1, 1'b1, 1'b1, 24'($urandom));
        if (LOCKED !== 1'b0) locked_seen++;
      end
      repeat (3) drive(1'b1, 1'b0, 1'b1, 24'h0);
    end
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL seek_writes got %0d want 0", wr_q.size()); end
    checks++; if (locked_seen != 0) begin errors++; $display("FAIL seek_locked got %0d high cycles want 0", locked_seen); end
  endtask

  task automatic test_lock_latency();
    repeat (3) drive(1'b0, 1'b0, 1'b1, 24'h0);
    @(negedge clk); VS = 1'b1;
    @(posedge clk); #1;
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL lock_early got %b want 0", LOCKED); end
    @(posedge clk); #1;
    checks++; if (LOCKED !== 1'b1) begin errors++; $display("FAIL lock_two_cycles got %b want 1", LOCKED); end
    repeat (2) drive(1'b1, 1'b0, 1'b1, 24'h0);
    @(negedge clk); DE = 1'b1; PIX_DATA = 24'hABCDEF;
    @(posedge clk); #1;
    checks++; if (RAM_WE !== 1'b0) begin errors++; $display("FAIL lat_edge_n got %b want 0", RAM_WE); end
    @(negedge clk); DE = 1'b0; PIX_DATA = 24'h0;
    @(posedge clk); #1;
    checks++; if (RAM_WE !== 1'b0) begin errors++; $display("FAIL lat_edge_n1 got %b want 0", RAM_WE); end
    @(posedge clk); #1;
    checks++; if (RAM_WE !== 1'b1) begin errors++; $display("FAIL lat_we got %b want 1", RAM_WE); end
    checks++; if (RAM_ADDR !== 19'h0) begin errors++; $display("FAIL lat_addr got %h want 0", RAM_ADDR); end
    checks++; if (RAM_WDATA !== 24'hABCDEF) begin errors++; $display("FAIL lat_data got %h want abcdef", RAM_WDATA); end
  endtask

  task automatic test_full_frame();
    int bad, addr_ne_data;
    do_reset();
    nlines = V; data_mode = 1;
    for (int l = 0; l < 32; l++) line_len[l] = H;
    drive_frame();
    bad = -1; addr_ne_data = 0;
    foreach (wr_q[i]) begin
      if (i < exp_q.size() && wr_q[i] !== exp_q[i] && bad < 0) bad = i;
      if (24'(wr_q[i][42:24]) !== wr_q[i][23:0]) addr_ne_data++;
    end
    checks++; if (wr_q.size() != H * V) begin errors++; $display("FAIL full_count got %0d want %0d", wr_q.size(), H * V); end
    checks++; if (bad >= 0) begin errors++; $display("FAIL full_data idx %0d got %h want %h", bad, wr_q[bad], exp_q[bad]); end
    checks++; if (addr_ne_data != 0) begin errors++; $display("FAIL full_addr_eq_data got %0d differing want 0", addr_ne_data); end
    checks++;
    if (wr_q.size() == 0 || wr_q[wr_q.size()-1][42:24] !== 19'(H * V - 1)) begin
      errors++; $display("FAIL full_last_addr got %0d writes want last addr %0d", wr_q.size(), H * V - 1);
    end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL full_fd got %0d want 1", fd_cnt); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL full_err got %b want 0", ERR); end
  endtask

  task automatic test_long_line();
    int bad;
    do_reset();
    nlines = V; data_mode = 0;
    for (int l = 0; l < 32; l++) line_len[l] = H;
    line_len[2] = H + 10;
    drive_frame();
    bad = -1;
    foreach (wr_q[i]) if (i < exp_q.size() && wr_q[i] !== exp_q[i] && bad < 0) bad = i;
    checks++; if (wr_q.size() != H * V) begin errors++; $display("FAIL long_count got %0d want %0d", wr_q.size(), H * V); end
    checks++; if (bad >= 0) begin errors++; $display("FAIL long_data idx %0d got %h want %h", bad, wr_q[bad], exp_q[bad]); end
    checks++;
    if (wr_q.size() <= 3 * H || wr_q[3 * H][42:24] !== 19'(3 * H)) begin
      errors++; $display("FAIL long_next_line got %0d writes want line 3 start at %0d", wr_q.size(), 3 * H);
    end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL long_fd got %0d want 1", fd_cnt); end
    checks++; if (ERR !== ERR_ON) begin errors++; $display("FAIL long_err got %b want %b", ERR, ERR_ON); end
  endtask

  task automatic test_short_frame();
    int bad;
    do_reset();
    nlines = V - 1; data_mode = 0;
    for (int l = 0; l < 32; l++) line_len[l] = H;
    drive_frame();
    bad = -1;
    foreach (wr_q[i]) if (i < exp_q.size() && wr_q[i] !== exp_q[i] && bad < 0) bad = i;
    checks++; if (wr_q.size() != exp_q.size()) begin errors++; $display("FAIL short_count got %0d want %0d", wr_q.size(), exp_q.size()); end
    checks++; if (bad >= 0) begin errors++; $display("FAIL short_data idx %0d got %h want %h", bad, wr_q[bad], exp_q[bad]); end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL short_fd got %0d want 1", fd_cnt); end
    checks++; if (ERR !== ERR_ON) begin errors++; $display("FAIL short_err got %b want %b", ERR, ERR_ON); end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    do_reset();
    repeat (3) drive(1'b0, 1'b0, 1'b1, 24'h0);
    repeat (2) drive(1'b1, 1'b0, 1'b1, 24'h0);
    for (int l = 0; l < 3; l++) begin
      for (int p = 0; p < H; p++) drive(1'b1, 1'b1, 1'b1, 24'($urandom));
      repeat (3) drive(1'b1, 1'b0, 1'b1, 24'h0);
    end
    for (int p = 0; p < H / 2; p++) drive(1'b1, 1'b1, 1'b1, 24'($urandom));
    #2;
    checks++; if (RAM_WE !== 1'b1) begin errors++; $display("FAIL mid_busy_we got %b want 1", RAM_WE); end
    rst = 1'b1;
    #1;
    checks++; if (RAM_WE !== 1'b0) begin errors++; $display("FAIL mid_rst_we got %b want 0", RAM_WE); end
    checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL mid_rst_locked got %b want 0", LOCKED); end
    wr_q.delete();
    fd_cnt = 0;
    repeat (2) drive(1'b1, 1'b1, 1'b1, 24'($urandom));
    rst = 1'b0;
    for (int p = 0; p < H / 2; p++) drive(1'b1, 1'b1, 1'b1, 24'($urandom));
    for (int l = 4; l < V; l++) begin
      repeat (3) drive(1'b1, 1'b0, 1'b1, 24'h0);
      for (int p = 0; p < H; p++) drive(1'b1, 1'b1, 1'b1, 24'($urandom));
    end
    repeat (3) drive(1'b1, 1'b0, 1'b1, 24'h0);
    repeat (6) drive(1'b0, 1'b0, 1'b1, 24'h0);
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL mid_aborted_writes got %0d want 0", wr_q.size()); end
    checks++; if (fd_cnt != 0) begin errors++; $display("FAIL mid_aborted_fd got %0d want 0", fd_cnt); end
    nlines = V; data_mode = 0;
    for (int l = 0; l < 32; l++) line_len[l] = H;
    drive_frame();
    bad = -1;
    foreach (wr_q[i]) if (i < exp_q.size() && wr_q[i] !== exp_q[i] && bad < 0) bad = i;
    checks++;
    if (wr_q.size() == 0 || wr_q[0][42:24] !== 19'h0) begin
      errors++; $display("FAIL mid_next_first got %0d writes want first addr 0", wr_q.size());
    end
    checks++; if (wr_q.size() != H * V) begin errors++; $display("FAIL mid_next_count got %0d want %0d", wr_q.size(), H * V); end
    checks++; if (bad >= 0) begin errors++; $display("FAIL mid_next_data idx %0d got %h want %h", bad, wr_q[bad], exp_q[bad]); end
  endtask

  task automatic test_random_frames();
    int bad, r;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      r = $urandom_range(0, 3);
      nlines = (r == 0) ? V - 1 : (r == 1) ? V + 1 : V;
      data_mode = 0;
      for (int l = 0; l < 32; l++)
        line_len[l] = ($urandom_range(0, 3) == 0) ? H - 3 + $urandom_range(0, 6) : H;
      drive_frame();
      bad = -1;
      foreach (wr_q[i]) if (i < exp_q.size() && wr_q[i] !== exp_q[i] && bad < 0) bad = i;
      checks++; if (wr_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", f, wr_q.size(), exp_q.size()); end
      checks++; if (bad >= 0) begin errors++; $display("FAIL rand%0d_data idx %0d got %h want %h", f, bad, wr_q[bad], exp_q[bad]); end
      checks++; if (fd_cnt != 1) begin errors++; $display("FAIL rand%0d_fd got %0d want 1", f, fd_cnt); end
      checks++; if (ERR !== (exp_err & ERR_ON)) begin errors++; $display("FAIL rand%0d_err got %b want %b", f, ERR, exp_err & ERR_ON); end
    end
  endtask

  initial begin
    test_reset();
    test_seek();
    test_lock_latency();
    test_full_frame();
    test_long_line();
    test_short_frame();
    test_reset_mid_frame();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter H_VISIBLE, default 640: active pixels per line.
REQ-002 Parameter V_VISIBLE, default 480: active lines per frame.
REQ-003 clk  input  1  pixel clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 HS  input  1  horizontal sync, active-low.
REQ-006 VS  input  1  vertical sync, active-low.
REQ-007 DE  input  1  data enable, high during active pixels.
REQ-008 PIX_DATA  input  24  pixel value, valid when DE=1.
REQ-009 RAM_ADDR  output  19  framebuffer write address.
REQ-010 RAM_WDATA  output  24  framebuffer write data.
REQ-011 RAM_WE  output  1  write strobe, one write per cycle high.
REQ-012 FRAME_DONE  output  1  one-cycle pulse when a frame completes.
REQ-013 LOCKED  output  1  high while in CAPTURE state.
REQ-014 ERR  output  1  sticky geometry error flag.

Function
REQ-015 HS, VS, DE and PIX_DATA SHALL be registered once (stage 1) before any decision.
REQ-016 The FSM SHALL have states SEEK and CAPTURE; reset enters SEEK.
REQ-017 SEEK: no writes; on stage-1 VS rising edge (0->1) go to CAPTURE, clear line/pixel counters, address and ERR.
REQ-018 CAPTURE: each stage-1 DE=1 cycle with pixel<H_VISIBLE and line<V_VISIBLE SHALL produce one write.
REQ-019 Write latency: a pixel on PIX_DATA with DE=1 at input edge n SHALL appear as RAM_WE=1, RAM_WDATA=pixel, RAM_ADDR=line*H_VISIBLE+pixel after edge n+2.
REQ-020 RAM_ADDR SHALL be maintained incrementally (+1 per write), no multiplier; first write of a frame at address 0.
REQ-021 Pixel counter SHALL reset to 0 on each stage-1 DE falling edge; line counter SHALL increment on that edge.
REQ-022 Pixels beyond H_VISIBLE in a line, or any DE=1 with line>=V_VISIBLE, SHALL be dropped (RAM_WE=0, address unchanged).
REQ-023 On stage-1 VS falling edge (1->0) in CAPTURE: FRAME_DONE SHALL pulse one cycle, re-arm counters and address to 0, stay in CAPTURE.
REQ-024 RAM_WE SHALL be 0 whenever no valid write is issued; RAM_ADDR/RAM_WDATA hold last value.
REQ-025 HS SHALL be registered but not used for addressing; DE edges define lines.
REQ-026 Simultaneous VS falling edge and DE=1 in stage 1: the pixel SHALL be written first, then counters re-arm.
REQ-027 LOCKED SHALL equal (state==CAPTURE).

Reset
REQ-028 On rst=1, immediately: state=SEEK, RAM_WE=0, RAM_ADDR=0, RAM_WDATA=0, FRAME_DONE=0, LOCKED=0, ERR=0, counters and stage-1 registers 0.
REQ-029 Reset mid-frame SHALL abort the frame with no further writes; capture resumes only after the next VS rising edge.

Configuration
REQ-030 Macro VGA_CAPTURE_ERR_EN defined: ERR SHALL set when a line ends with pixel count != H_VISIBLE, or a frame ends (VS falling edge) with line count != V_VISIBLE; sticky until next VS rising edge or reset.
REQ-031 Macro VGA_CAPTURE_ERR_EN undefined: ERR SHALL be constant 0 and the checking logic absent; all other behaviour identical.

Verification
REQ-032 Full 800x525 frame, 640x480 active, PIX_DATA=addr -> exactly 307200 writes, RAM_WDATA==RAM_ADDR, last address 307199, one FRAME_DONE, ERR=0.
REQ-033 Latency: first DE=1 with PIX_DATA=24'hABCDEF at edge n -> RAM_WE=1, RAM_ADDR=0, RAM_WDATA=24'hABCDEF after edge n+2.
REQ-034 Line with 650 DE cycles -> only 640 writes that line, next line starts at line*640; ERR=1 with macro, 0 without.
REQ-035 Data before the first VS rising edge after reset -> zero writes, LOCKED=0; LOCKED=1 two cycles after VS input rises.
REQ-036 rst pulsed at line 100 -> RAM_WE=0 at once; next frame's first write at address 0.
REQ-037 Frame with 479 active lines -> FRAME_DONE pulses once; ERR=1 with macro.
